// File: rtl/regfile_sb_if.sv
// Register file port bundle: two read ports, one write port, reserve/flush
// controls and the pending counter. The master is the decode/issue side and
// the slave is the register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rg_rd_addr1;
    logic [ADDR_W-1:0] rg_rd_addr2;
    logic [DATA_W-1:0] rg_rd_data1;
    logic [DATA_W-1:0] rg_rd_data2;
    logic              rg_rd_busy1;
    logic              rg_rd_busy2;
    logic              rg_wrt_en;
    logic [ADDR_W-1:0] rg_wrt_addr;
    logic [DATA_W-1:0] rg_wrt_data;
    logic              rg_rsv_en;
    logic [ADDR_W-1:0] rg_rsv_addr;
    logic              rg_rsv_ok;
    logic              rg_flush;
    logic [ADDR_W:0]   rg_pend_cnt;

    modport master (
        output rg_rd_addr1, rg_rd_addr2, rg_wrt_en, rg_wrt_addr, rg_wrt_data,
               rg_rsv_en, rg_rsv_addr, rg_flush,
        input  rg_rd_data1, rg_rd_data2, rg_rd_busy1, rg_rd_busy2, rg_rsv_ok,
               rg_pend_cnt
    );

    modport slave (
        input  rg_rd_addr1, rg_rd_addr2, rg_wrt_en, rg_wrt_addr, rg_wrt_data,
               rg_rsv_en, rg_rsv_addr, rg_flush,
        output rg_rd_data1, rg_rd_data2, rg_rd_busy1, rg_rd_busy2, rg_rsv_ok,
               rg_pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one synchronous write port
// and a per-register busy scoreboard so decode can stall on operands whose
// long-latency writes are still outstanding.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic          clk,
    input logic          reset,
    regfile_sb_if.slave  rg
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic wrt_zero, rsv_zero;
    logic wrt_eff;
    logic rsv_ok;
    logic rsv_set;
    logic cnt_inc, cnt_dec;

    // Decode write/reserve qualification shared by the scoreboard and read ports.
    always_comb begin
        wrt_zero = (ZERO_REG != 0) && (rg.rg_wrt_addr == '0);
        rsv_zero = (ZERO_REG != 0) && (rg.rg_rsv_addr == '0);
        wrt_eff  = rg.rg_wrt_en && !wrt_zero;
        // A same-cycle write to the reserved register hands it to the new owner.
        rsv_ok   = rg.rg_rsv_en && !rg.rg_flush &&
                   (!busy_q[rg.rg_rsv_addr] ||
                    (rg.rg_wrt_en && (rg.rg_wrt_addr == rg.rg_rsv_addr)));
        rsv_set  = rsv_ok && !rsv_zero;
        // Bit goes (or stays) set after the write is accounted for, so +1 always.
        cnt_inc  = rsv_set;
        cnt_dec  = wrt_eff && busy_q[rg.rg_wrt_addr];
    end

    // Next busy vector and pending counter; flush wins over everything.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (wrt_eff) begin
            busy_d[rg.rg_wrt_addr] = 1'b0;
        end
        if (rsv_set) begin
            busy_d[rg.rg_rsv_addr] = 1'b1;
        end
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!cnt_inc && cnt_dec) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (rg.rg_flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    // Storage, scoreboard and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wrt_eff) begin
                mem_q[rg.rg_wrt_addr] <= rg.rg_wrt_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports with optional write forwarding; everything forced low in reset.
    always_comb begin
        rg.rg_rd_data1 = mem_q[rg.rg_rd_addr1];
        rg.rg_rd_data2 = mem_q[rg.rg_rd_addr2];
        rg.rg_rd_busy1 = busy_q[rg.rg_rd_addr1];
        rg.rg_rd_busy2 = busy_q[rg.rg_rd_addr2];
        if ((BYPASS != 0) && wrt_eff && (rg.rg_wrt_addr == rg.rg_rd_addr1)) begin
            rg.rg_rd_data1 = rg.rg_wrt_data;
            rg.rg_rd_busy1 = 1'b0;
        end
        if ((BYPASS != 0) && wrt_eff && (rg.rg_wrt_addr == rg.rg_rd_addr2)) begin
            rg.rg_rd_data2 = rg.rg_wrt_data;
            rg.rg_rd_busy2 = 1'b0;
        end
        rg.rg_rsv_ok   = rsv_ok;
        rg.rg_pend_cnt = cnt_q;
        if (reset) begin
            rg.rg_rd_data1 = '0;
            rg.rg_rd_data2 = '0;
            rg.rg_rd_busy1 = 1'b0;
            rg.rg_rd_busy2 = 1'b0;
            rg.rg_rsv_ok   = 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. The driver applies one vector per cycle just
// after the rising edge and queues the expected combinational response; the
// monitor pops and compares on the falling edge.
module tb_regfile_sb;
    logic clk;
    logic reset;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) rg ();

    regfile_sb #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .ZERO_REG(1),
        .BYPASS  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rg   (rg)
    );

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic        ok;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got 0x%0h required 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "rd_data1", rg.rg_rd_data1, e.d1);
                cmp(e.name, "rd_busy1", 32'(rg.rg_rd_busy1), 32'(e.b1));
                cmp(e.name, "rd_data2", rg.rg_rd_data2, e.d2);
                cmp(e.name, "rd_busy2", 32'(rg.rg_rd_busy2), 32'(e.b2));
                cmp(e.name, "rsv_ok", 32'(rg.rg_rsv_ok), 32'(e.ok));
                cmp(e.name, "pend_cnt", 32'(rg.rg_pend_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic re,
                         input logic [4:0] ra, input logic fl);
        rg.rg_rd_addr1 = a1;
        rg.rg_rd_addr2 = a2;
        rg.rg_wrt_en   = we;
        rg.rg_wrt_addr = wa;
        rg.rg_wrt_data = wd;
        rg.rg_rsv_en   = re;
        rg.rg_rsv_addr = ra;
        rg.rg_flush    = fl;
    endtask

    task automatic push(input string nm, input logic [31:0] d1, input logic b1,
                        input logic [31:0] d2, input logic b2, input logic ok,
                        input logic [5:0] cnt);
        exp_t e;
        e.name = nm;
        e.d1   = d1;
        e.b1   = b1;
        e.d2   = d2;
        e.b2   = b2;
        e.ok   = ok;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // One cycle: inputs (a1 a2 we wa wd re ra fl), expected (d1 b1 d2 b2 ok cnt).
    task automatic vec(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra, input logic fl,
                       input logic [31:0] d1, input logic b1, input logic [31:0] d2,
                       input logic b2, input logic ok, input logic [5:0] cnt);
        @(posedge clk);
        #1;
        drive(a1, a2, we, wa, wd, re, ra, fl);
        push(nm, d1, b1, d2, b2, ok, cnt);
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #12 reset = 1'b0;

        vec("rst_state",  5'd0, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 0, 6'd0);
        vec("wr_x5_byp",  5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0,
            32'hDEADBEEF, 0, 32'h0, 0, 0, 6'd0);
        vec("rd_x5",      5'd5, 5'd5, 0, 5'd0, 32'h0,        0, 5'd0, 0,
            32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 6'd0);

        // Mid-cycle reset while a write and reserve to x5 are presented.
        @(posedge clk);
        #1;
        drive(5'd5, 5'd5, 1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 1'b0);
        #1 reset = 1'b1;
        push("rst_hold", 32'h0, 0, 32'h0, 0, 0, 6'd0);
        @(posedge clk);
        #1;
        drive(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1 reset = 1'b0;
        push("rst_after", 32'h0, 0, 32'h0, 0, 0, 6'd0);

        vec("wr_x3_byp",  5'd3, 5'd3, 1, 5'd3, 32'h1234, 0, 5'd0, 0,
            32'h1234, 0, 32'h1234, 0, 0, 6'd0);
        vec("rd_x3",      5'd3, 5'd5, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h1234, 0, 32'h0, 0, 0, 6'd0);

        vec("rsv_x7",     5'd7, 5'd3, 0, 5'd0, 32'h0,    1, 5'd7, 0,
            32'h0, 0, 32'h1234, 0, 1, 6'd0);
        vec("rsv_x7_dup", 5'd7, 5'd3, 0, 5'd0, 32'h0,    1, 5'd7, 0,
            32'h0, 1, 32'h1234, 0, 0, 6'd1);
        vec("wr_x7",      5'd7, 5'd7, 1, 5'd7, 32'h55,   0, 5'd0, 0,
            32'h55, 0, 32'h55, 0, 0, 6'd1);
        vec("x7_clear",   5'd7, 5'd7, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h55, 0, 32'h55, 0, 0, 6'd0);

        vec("rsv_x9",     5'd9, 5'd7, 0, 5'd0, 32'h0,    1, 5'd9, 0,
            32'h0, 0, 32'h55, 0, 1, 6'd0);
        vec("wr_rsv_x9",  5'd9, 5'd9, 1, 5'd9, 32'hA5A5, 1, 5'd9, 0,
            32'hA5A5, 0, 32'hA5A5, 0, 1, 6'd1);
        vec("x9_busy",    5'd9, 5'd9, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'hA5A5, 1, 32'hA5A5, 1, 0, 6'd1);
        vec("wr_x9",      5'd9, 5'd7, 1, 5'd9, 32'h9999, 0, 5'd0, 0,
            32'h9999, 0, 32'h55, 0, 0, 6'd1);

        vec("rsv_x1",     5'd1, 5'd2, 0, 5'd0, 32'h0,    1, 5'd1, 0,
            32'h0, 0, 32'h0, 0, 1, 6'd0);
        vec("rsv_x2",     5'd1, 5'd2, 0, 5'd0, 32'h0,    1, 5'd2, 0,
            32'h0, 1, 32'h0, 0, 1, 6'd1);
        vec("rsv_x4",     5'd2, 5'd4, 0, 5'd0, 32'h0,    1, 5'd4, 0,
            32'h0, 1, 32'h0, 0, 1, 6'd2);
        vec("flush_rsv6", 5'd4, 5'd6, 0, 5'd0, 32'h0,    1, 5'd6, 1,
            32'h0, 1, 32'h0, 0, 0, 6'd3);
        vec("post_fl_a",  5'd1, 5'd6, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 0, 6'd0);
        vec("post_fl_b",  5'd2, 5'd4, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 0, 6'd0);

        vec("wr_x0",      5'd0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 0, 6'd0);
        vec("rd_x0",      5'd0, 5'd3, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h0, 0, 32'h1234, 0, 0, 6'd0);
        vec("rsv_x0",     5'd0, 5'd0, 0, 5'd0, 32'h0,    1, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 1, 6'd0);
        vec("x0_idle",    5'd0, 5'd0, 0, 5'd0, 32'h0,    0, 5'd0, 0,
            32'h0, 0, 32'h0, 0, 0, 6'd0);

        vec("rsv_x10",    5'd10, 5'd0, 0, 5'd0,  32'h0,  1, 5'd10, 0,
            32'h0, 0, 32'h0, 0, 1, 6'd0);
        vec("flush_wr10", 5'd10, 5'd0, 1, 5'd10, 32'h77, 0, 5'd0,  1,
            32'h77, 0, 32'h0, 0, 0, 6'd1);
        vec("x10_after",  5'd10, 5'd9, 0, 5'd0,  32'h0,  0, 5'd0,  0,
            32'h77, 0, 32'h9999, 0, 0, 6'd0);

        @(posedge clk);
        #1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
